// File: rtl/vga_timing_pipe_if.sv
// Bundle between the VGA timing/output stage and its renderer and display consumers.
// The master side is the timing generator; the slave side is the renderer/sink.
interface vga_timing_pipe_if #(
  parameter int CW = 11,
  parameter int RW = 3,
  parameter int GW = 3,
  parameter int BW = 2
);
  logic          pixel_en;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          vidon;
  logic          frame_start;
  logic          line_start;
  logic [RW-1:0] r_in;
  logic [GW-1:0] g_in;
  logic [BW-1:0] b_in;
  logic          hsync;
  logic          vsync;
  logic [RW-1:0] red;
  logic [GW-1:0] green;
  logic [BW-1:0] blue;

  modport master (
    input  pixel_en, r_in, g_in, b_in,
    output x, y, vidon, frame_start, line_start, hsync, vsync, red, green, blue
  );

  modport slave (
    output pixel_en, r_in, g_in, b_in,
    input  x, y, vidon, frame_start, line_start, hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/vga_timing_pipe.sv
// VGA timing generator and registered output stage on the system clock, qualified by pixel_en.
// Sync and blanking flags are delayed to meet the renderer's colour so all outputs share one pixel.
module vga_timing_pipe #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int PIX_LAT   = 2,
  parameter int CW        = 11,
  parameter int RW        = 3,
  parameter int GW        = 3,
  parameter int BW        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_pipe_if.master bus
);

  localparam int H_TOT        = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT        = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);

  localparam int FLAG_ACT = 2;
  localparam int FLAG_HS  = 1;
  localparam int FLAG_VS  = 0;

  if ((H_TOT - 1) >= (1 << CW) || (V_TOT - 1) >= (1 << CW)) begin : g_cw_check
    $error("vga_timing_pipe: H_TOT-1 or V_TOT-1 does not fit in CW bits");
  end

  if (PIX_LAT < 0) begin : g_lat_check
    $error("vga_timing_pipe: PIX_LAT must be non-negative");
  end

  // ---------------------------------------------------------------- counters
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (bus.pixel_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // ------------------------------------------------------- per-pixel flags
  logic       act;
  logic       hs;
  logic       vs;
  logic [2:0] cur_flags;

  always_comb begin
    act = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
    hs  = (int'(hc_q) >= H_SYNC_START) && (int'(hc_q) < H_SYNC_END);
    vs  = (int'(vc_q) >= V_SYNC_START) && (int'(vc_q) < V_SYNC_END);
    cur_flags           = '0;
    cur_flags[FLAG_ACT] = act;
    cur_flags[FLAG_HS]  = hs;
    cur_flags[FLAG_VS]  = vs;
  end

  assign bus.x           = hc_q;
  assign bus.y           = vc_q;
  assign bus.vidon       = act;
  assign bus.line_start  = bus.pixel_en && (hc_q == '0);
  assign bus.frame_start = bus.pixel_en && (hc_q == '0) && (vc_q == '0);

  // ------------------------------------------------------------ delay line
  // Flags travel alongside the renderer's latency so they meet its colour for the same pixel.
  logic [2:0] dly_flags;

  if (PIX_LAT == 0) begin : g_no_dly
    assign dly_flags = cur_flags;
  end else begin : g_dly
    logic [2:0] dly_q [PIX_LAT];
    logic [2:0] dly_d [PIX_LAT];

    always_comb begin
      for (int i = 0; i < PIX_LAT; i++) begin
        dly_d[i] = dly_q[i];
      end
      if (bus.pixel_en) begin
        dly_d[0] = cur_flags;
        for (int i = 1; i < PIX_LAT; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIX_LAT; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < PIX_LAT; i++) begin
          dly_q[i] <= dly_d[i];
        end
      end
    end

    assign dly_flags = dly_q[PIX_LAT-1];
  end

  // ---------------------------------------------------------- output stage
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [RW-1:0] red_q,   red_d;
  logic [GW-1:0] green_q, green_d;
  logic [BW-1:0] blue_q,  blue_d;

  // Blanking is applied here so renderer colour outside the active area never reaches the pins.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (bus.pixel_en) begin
      hsync_d = dly_flags[FLAG_HS] ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = dly_flags[FLAG_VS] ? VSYNC_POL : ~VSYNC_POL;
      red_d   = dly_flags[FLAG_ACT] ? bus.r_in : '0;
      green_d = dly_flags[FLAG_ACT] ? bus.g_in : '0;
      blue_d  = dly_flags[FLAG_ACT] ? bus.b_in : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.red   = red_q;
  assign bus.green = green_q;
  assign bus.blue  = blue_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Scoreboard bench for vga_timing_pipe on a 16x8 frame with renderer latencies 2, 0 and 3.
// Expected values come from pixel-count arithmetic; a negedge monitor compares every cycle.
module tb_vga_timing_pipe;

  localparam int HT = 16;
  localparam int VT = 8;
  localparam int CW = 4;
  localparam int LAT [3] = '{2, 0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       pe;
  logic [2:0] r_rnd;
  logic [2:0] g_rnd;
  logic [1:0] b_rnd;
  logic [2:0] xh1, xh2, xh3;
  bit         rnd_rgb;
  bit         mon_en;

  vga_timing_pipe_if #(.CW(CW), .RW(3), .GW(3), .BW(2)) if_l2 ();
  vga_timing_pipe_if #(.CW(CW), .RW(3), .GW(3), .BW(2)) if_l0 ();
  vga_timing_pipe_if #(.CW(CW), .RW(3), .GW(3), .BW(2)) if_l3 ();

  assign if_l2.pixel_en = pe;
  assign if_l0.pixel_en = pe;
  assign if_l3.pixel_en = pe;
  assign if_l2.r_in = r_rnd;
  assign if_l0.r_in = if_l0.x[2:0];
  assign if_l3.r_in = xh3;
  assign if_l2.g_in = g_rnd;
  assign if_l0.g_in = g_rnd;
  assign if_l3.g_in = g_rnd;
  assign if_l2.b_in = b_rnd;
  assign if_l0.b_in = b_rnd;
  assign if_l3.b_in = b_rnd;

  // Renderer with three steps of latency: returns x[2:0] of the pixel shown three steps ago.
  always @(posedge clk) begin
    if (rst_n && pe) begin
      xh1 <= if_l3.x[2:0];
      xh2 <= xh1;
      xh3 <= xh2;
    end
  end

  vga_timing_pipe #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LAT(2),
                    .CW(CW), .RW(3), .GW(3), .BW(2))
    dut_l2 (.clk(clk), .rst_n(rst_n), .bus(if_l2.master));

  vga_timing_pipe #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LAT(0),
                    .CW(CW), .RW(3), .GW(3), .BW(2))
    dut_l0 (.clk(clk), .rst_n(rst_n), .bus(if_l0.master));

  vga_timing_pipe #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LAT(3),
                    .CW(CW), .RW(3), .GW(3), .BW(2))
    dut_l3 (.clk(clk), .rst_n(rst_n), .bus(if_l3.master));

  typedef struct {
    int         x;
    int         y;
    bit         vidon;
    bit         fs;
    bit         ls;
    logic [9:0] o0;
    logic [9:0] o1;
    logic [9:0] o2;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       mon_e;
  int         checks;
  int         errors;
  int         k;
  logic [9:0] reg_o [3];

  // Output tuple {hsync,vsync,red,green,blue} after enable edge kk for a renderer of latency lat.
  function automatic logic [9:0] out_for(input int lat, input int kk, input logic [2:0] r,
                                         input logic [2:0] g, input logic [1:0] b);
    int         p;
    int         h;
    int         v;
    bit         act, hs, vs;
    logic [2:0] rr;
    p = kk - 1 - lat;
    if (p < 0) return 10'd0;
    h   = p % HT;
    v   = (p / HT) % VT;
    act = (h < 8) && (v < 4);
    hs  = (h >= 10) && (h < 13);
    vs  = (v >= 5) && (v < 7);
    rr  = (lat == 2) ? r : 3'(h % 8);
    return {hs, vs, act ? rr : 3'd0, act ? g : 3'd0, act ? b : 2'd0};
  endfunction

  task automatic cycle(input bit pe_in, input bit rst_in);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && pe) begin
      k++;
      for (int i = 0; i < 3; i++) reg_o[i] = out_for(LAT[i], k, r_rnd, g_rnd, b_rnd);
    end
    rst_n = rst_in;
    if (!rst_in) begin
      k = 0;
      for (int i = 0; i < 3; i++) reg_o[i] = 10'd0;
    end
    pe = pe_in;
    if (rnd_rgb) begin
      r_rnd = 3'($urandom);
      g_rnd = 3'($urandom);
      b_rnd = 2'($urandom);
    end
    e.x     = k % HT;
    e.y     = (k / HT) % VT;
    e.vidon = ((k % HT) < 8) && (((k / HT) % VT) < 4);
    e.fs    = pe_in && ((k % (HT * VT)) == 0);
    e.ls    = pe_in && ((k % HT) == 0);
    e.o0    = reg_o[0];
    e.o1    = reg_o[1];
    e.o2    = reg_o[2];
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (int'(if_l2.x) != mon_e.x || int'(if_l2.y) != mon_e.y || if_l2.vidon != mon_e.vidon ||
            if_l2.frame_start != mon_e.fs || if_l2.line_start != mon_e.ls) begin
          errors++;
          $display("FAIL coord t=%0t got x=%0d y=%0d von=%0b fs=%0b ls=%0b want x=%0d y=%0d von=%0b fs=%0b ls=%0b",
                   $time, if_l2.x, if_l2.y, if_l2.vidon, if_l2.frame_start, if_l2.line_start,
                   mon_e.x, mon_e.y, mon_e.vidon, mon_e.fs, mon_e.ls);
        end
        checks++;
        if ({if_l2.hsync, if_l2.vsync, if_l2.red, if_l2.green, if_l2.blue} != mon_e.o0) begin
          errors++;
          $display("FAIL out_lat2 t=%0t got %b want %b", $time,
                   {if_l2.hsync, if_l2.vsync, if_l2.red, if_l2.green, if_l2.blue}, mon_e.o0);
        end
        checks++;
        if ({if_l0.hsync, if_l0.vsync, if_l0.red, if_l0.green, if_l0.blue} != mon_e.o1) begin
          errors++;
          $display("FAIL out_lat0 t=%0t got %b want %b", $time,
                   {if_l0.hsync, if_l0.vsync, if_l0.red, if_l0.green, if_l0.blue}, mon_e.o1);
        end
        checks++;
        if ({if_l3.hsync, if_l3.vsync, if_l3.red, if_l3.green, if_l3.blue} != mon_e.o2) begin
          errors++;
          $display("FAIL out_lat3 t=%0t got %b want %b", $time,
                   {if_l3.hsync, if_l3.vsync, if_l3.red, if_l3.green, if_l3.blue}, mon_e.o2);
        end
      end
    end
  end

  initial begin
    int guard;
    rst_n   = 1'b0;
    pe      = 1'b0;
    r_rnd   = 3'd7;
    g_rnd   = 3'd0;
    b_rnd   = 2'd0;
    rnd_rgb = 1'b0;
    mon_en  = 1'b0;
    checks  = 0;
    errors  = 0;
    k       = 0;
    for (int i = 0; i < 3; i++) reg_o[i] = 10'd0;

    // Held in reset with pixel_en toggling and R_in=7, then released idle.
    for (int i = 0; i < 6; i++) cycle(i[0], 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

    // Continuous enable with constant red, a little over two frames.
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1);

    // One enable in four with random colour.
    rnd_rgb = 1'b1;
    for (int i = 0; i < 600; i++) cycle(i % 4 == 0, 1'b1);

    // Reset mid-frame at hc=5, vc=2.
    guard = 0;
    while ((k % (HT * VT)) != 37 && guard < 300) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    checks++;
    if ((k % (HT * VT)) != 37) begin
      errors++;
      $display("FAIL mid_reset_position got %0d want 37", k % (HT * VT));
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

    // Random enable duty after release.
    for (int i = 0; i < 500; i++) cycle(1'($urandom), 1'b1);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
